// File: rtl/xor_sweep_ctrl.sv
// Sweep sequencer and on-chip self-check for the XOR datapath (f = a ^ b).
// It drives every operand pair, waits out the datapath latency, and counts mismatches.
module xor_sweep_ctrl #(
  parameter int WIDTH = 4,
  parameter int LAT   = 1,
  parameter int ERRW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             op_valid,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] dp_f,
  output logic [ERRW-1:0]  err_cnt,
  output logic             ferr_vld,
  output logic [WIDTH-1:0] ferr_a,
  output logic [WIDTH-1:0] ferr_b
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  localparam int         IDXW      = 2 * WIDTH;
  localparam logic [2:0] WAIT_LAST = 3'((LAT > 0) ? LAT - 1 : 0);

  state_t           r_state;
  logic [IDXW-1:0]  r_idx;
  logic [2:0]       r_wcnt;
  logic             r_busy;
  logic             r_done;
  logic             r_op_valid;
  logic [ERRW-1:0]  r_err;
  logic             r_ferr_vld;
  logic [WIDTH-1:0] r_ferr_a;
  logic [WIDTH-1:0] r_ferr_b;

  logic w_mis;
  logic w_last;

  function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
    return (&v) ? v : v + ERRW'(1);
  endfunction

  // Operands come straight from the index register, so they stay stable
  // from DRIVE through CHECK and keep the last vector after the sweep.
  assign op_a     = r_idx[IDXW-1:WIDTH];
  assign op_b     = r_idx[WIDTH-1:0];
  assign w_mis    = (dp_f != (op_a ^ op_b));
  assign w_last   = &r_idx;

  assign busy     = r_busy;
  assign done     = r_done;
  assign op_valid = r_op_valid;
  assign err_cnt  = r_err;
  assign ferr_vld = r_ferr_vld;
  assign ferr_a   = r_ferr_a;
  assign ferr_b   = r_ferr_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_wcnt     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_op_valid <= 1'b0;
      r_err      <= '0;
      r_ferr_vld <= 1'b0;
      r_ferr_a   <= '0;
      r_ferr_b   <= '0;
    end else begin
      r_done     <= 1'b0;
      r_op_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx      <= '0;
            r_err      <= '0;
            r_ferr_vld <= 1'b0;
            r_ferr_a   <= '0;
            r_ferr_b   <= '0;
            r_busy     <= 1'b1;
            r_op_valid <= 1'b1;
            r_state    <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          r_wcnt  <= '0;
          r_state <= (LAT > 0) ? S_WAIT : S_CHECK;
        end
        S_WAIT: begin
          if (r_wcnt == WAIT_LAST) r_state <= S_CHECK;
          else                     r_wcnt  <= r_wcnt + 3'd1;
        end
        S_CHECK: begin
          if (w_mis) begin
            r_err <= sat_inc(r_err);
            if (!r_ferr_vld) begin
              r_ferr_vld <= 1'b1;
              r_ferr_a   <= op_a;
              r_ferr_b   <= op_b;
            end
          end
          // The sweep stops on the all-ones index; it never wraps.
          if (w_last) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx      <= r_idx + IDXW'(1);
            r_op_valid <= 1'b1;
            r_state    <= S_DRIVE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xor_sweep_ctrl.sv
// Bench for xor_sweep_ctrl: three instances (LAT=1/ERRW=16, LAT=0/ERRW=2, LAT=2)
// with modelled datapaths; sweep results are checked through a scoreboard queue.
module tb_xor_sweep_ctrl;

  typedef struct {
    int cyc;
    int err;
    bit fv;
    int fa;
    int fb;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start      [3];
  logic       busy_w     [3];
  logic       done_w     [3];
  logic       op_valid_w [3];
  logic [1:0] op_a_w     [3];
  logic [1:0] op_b_w     [3];
  logic [1:0] dp_f_w     [3];
  logic       ferr_vld_w [3];
  logic [1:0] ferr_a_w   [3];
  logic [1:0] ferr_b_w   [3];
  logic [15:0] errA;
  logic [1:0]  errB;
  logic [15:0] errC;

  logic [1:0] maskA;
  logic [1:0] dpA;
  logic [1:0] dpC_s1, dpC_s2;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  // Datapath models: A is one register deep with a bit mask fault,
  // B is stuck at zero, C is an ideal two-stage pipeline.
  always_ff @(posedge clk) begin
    dpA    <= (op_a_w[0] ^ op_b_w[0]) & maskA;
    dpC_s1 <= op_a_w[2] ^ op_b_w[2];
    dpC_s2 <= dpC_s1;
  end
  assign dp_f_w[0] = dpA;
  assign dp_f_w[1] = 2'b00;
  assign dp_f_w[2] = dpC_s2;

  xor_sweep_ctrl #(.WIDTH(2), .LAT(1), .ERRW(16)) u_dut_a (
    .clk(clk), .rst(rst), .start(start[0]), .busy(busy_w[0]), .done(done_w[0]),
    .op_valid(op_valid_w[0]), .op_a(op_a_w[0]), .op_b(op_b_w[0]), .dp_f(dp_f_w[0]),
    .err_cnt(errA), .ferr_vld(ferr_vld_w[0]), .ferr_a(ferr_a_w[0]), .ferr_b(ferr_b_w[0])
  );

  xor_sweep_ctrl #(.WIDTH(2), .LAT(0), .ERRW(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start[1]), .busy(busy_w[1]), .done(done_w[1]),
    .op_valid(op_valid_w[1]), .op_a(op_a_w[1]), .op_b(op_b_w[1]), .dp_f(dp_f_w[1]),
    .err_cnt(errB), .ferr_vld(ferr_vld_w[1]), .ferr_a(ferr_a_w[1]), .ferr_b(ferr_b_w[1])
  );

  xor_sweep_ctrl #(.WIDTH(2), .LAT(2), .ERRW(16)) u_dut_c (
    .clk(clk), .rst(rst), .start(start[2]), .busy(busy_w[2]), .done(done_w[2]),
    .op_valid(op_valid_w[2]), .op_a(op_a_w[2]), .op_b(op_b_w[2]), .dp_f(dp_f_w[2]),
    .err_cnt(errC), .ferr_vld(ferr_vld_w[2]), .ferr_a(ferr_a_w[2]), .ferr_b(ferr_b_w[2])
  );

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int err_of(input int d);
    case (d)
      0:       return int'(errA);
      1:       return int'(errB);
      default: return int'(errC);
    endcase
  endfunction

  // Reference sweep result from the bench's own datapath fault model.
  function automatic exp_t model(input int d, input int lat, input int emax, input logic [1:0] m);
    exp_t e;
    logic [1:0] a, b, f;
    e.cyc = 16 * (lat + 2) + 1;
    e.err = 0; e.fv = 1'b0; e.fa = 0; e.fb = 0;
    for (int idx = 0; idx < 16; idx++) begin
      a = 2'(idx >> 2);
      b = 2'(idx & 3);
      f = (d == 1) ? 2'b00 : ((d == 0) ? ((a ^ b) & m) : (a ^ b));
      if (f != (a ^ b)) begin
        if (e.err < emax) e.err++;
        if (!e.fv) begin
          e.fv = 1'b1; e.fa = int'(a); e.fb = int'(b);
        end
      end
    end
    return e;
  endfunction

  task automatic run_sweep(input int d, input int lat, input int emax,
                           input logic [1:0] m, input bit repulse);
    exp_t e;
    int   cyc, vexp, per;
    bit   got;
    exp_q.push_back(model(d, lat, emax, m));
    per = lat + 2;
    @(negedge clk);
    if (d == 0) maskA = m;
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    check_eq("clr_err", err_of(d), 0);
    check_eq("clr_ferr_vld", ferr_vld_w[d], 0);
    cyc = 1; got = 1'b0; vexp = 0;
    while (!got && cyc <= 200) begin
      start[d] = repulse && (cyc == 5 || cyc == 20);
      if (done_w[d]) got = 1'b1;
      else begin
        check_eq("busy", busy_w[d], 1);
        check_eq("op_valid", op_valid_w[d], ((cyc - 1) % per) == 0);
        if (op_valid_w[d]) begin
          check_eq("op_ab", {op_a_w[d], op_b_w[d]}, vexp);
          vexp++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start[d] = 1'b0;
    e = exp_q.pop_front();
    check_eq("done_seen", got, 1);
    check_eq("done_cyc", cyc, e.cyc);
    check_eq("busy_in_done", busy_w[d], 1);
    check_eq("vectors", vexp, 16);
    check_eq("err_cnt", err_of(d), e.err);
    check_eq("ferr_vld", ferr_vld_w[d], e.fv);
    if (e.fv) begin
      check_eq("ferr_a", ferr_a_w[d], e.fa);
      check_eq("ferr_b", ferr_b_w[d], e.fb);
    end
  endtask

  task automatic idle_after(input int d, input int ncyc);
    int dones = 0;
    @(negedge clk);
    check_eq("idle_busy", busy_w[d], 0);
    check_eq("hold_op_a", op_a_w[d], 3);
    check_eq("hold_op_b", op_b_w[d], 3);
    for (int i = 0; i < ncyc; i++) begin
      if (done_w[d]) dones++;
      @(negedge clk);
    end
    check_eq("extra_done", dones, 0);
  endtask

  initial begin
    int dones;
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dones;
    rst = 1'b1;
    maskA = 2'b11;
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check_eq("rst_busy", busy_w[d], 0);
      check_eq("rst_done", done_w[d], 0);
      check_eq("rst_op_valid", op_valid_w[d], 0);
      check_eq("rst_op_ab", {op_a_w[d], op_b_w[d]}, 0);
      check_eq("rst_err", err_of(d), 0);
      check_eq("rst_ferr", {ferr_vld_w[d], ferr_a_w[d], ferr_b_w[d]}, 0);
    end
    rst = 1'b0;

    run_sweep(0, 1, 65535, 2'b11, 1'b0);
    run_sweep(0, 1, 65535, 2'b10, 1'b0);
    idle_after(0, 4);
    run_sweep(1, 0, 3, 2'b00, 1'b0);
    idle_after(1, 4);
    run_sweep(2, 2, 65535, 2'b11, 1'b1);
    idle_after(2, 80);

    // Mid-sweep reset with a fault present so err_cnt is nonzero beforehand.
    @(negedge clk);
    maskA = 2'b10;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (9) @(negedge clk);
    check_eq("pre_rst_err", err_of(0), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_busy", busy_w[0], 0);
    check_eq("mid_rst_op_ab", {op_a_w[0], op_b_w[0]}, 0);
    check_eq("mid_rst_err", err_of(0), 0);
    check_eq("mid_rst_ferr", ferr_vld_w[0], 0);
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      if (done_w[0]) dones++;
      @(negedge clk);
    end
    check_eq("mid_rst_no_done", dones, 0);
    run_sweep(0, 1, 65535, 2'b11, 1'b0);

    // Back-to-back: a faulty sweep then an immediate clean one.
    run_sweep(0, 1, 65535, 2'b10, 1'b0);
    run_sweep(0, 1, 65535, 2'b11, 1'b0);
    idle_after(0, 4);

    check_eq("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
